// File: rtl/fpu_seq_pkg.sv
// Shared types and helpers for the state-memory sequencer: opcodes, FSM states,
// and the mapping from opcode to the enable-word bit that selects its write source.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MOV  = 3'd3,
        OP_NEG  = 3'd4,
        OP_ABS  = 3'd5,
        OP_IMM  = 3'd6,
        OP_LOAD = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int SRAM_BIT = 6;
    localparam int IMM_BIT  = 7;

    // ADD..ABS map straight onto bits 0-5; IMM and LOAD swap relative to opcode order.
    function automatic logic [2:0] srcbit(input op_t op);
        case (op)
            OP_IMM:  srcbit = 3'(IMM_BIT);
            OP_LOAD: srcbit = 3'(SRAM_BIT);
            default: srcbit = 3'(op);
        endcase
    endfunction

    function automatic logic is_fpu_op(input op_t op);
        is_fpu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/wb_word_decoder.sv
// Turns (dest, op, commit) into the flattened per-register enable vector;
// at most one bit of the whole vector is ever set.
module wb_word_decoder
    import fpu_seq_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic [$clog2(NREG)-1:0] dest,
    input  op_t                     op,
    input  logic                    commit,
    output logic [8*NREG-1:0]       en_word
);

    localparam int IW = $clog2(NREG);

    logic [7:0] sel_word;
    assign sel_word = 8'b1 << srcbit(op);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            assign en_word[8*gi +: 8] = (commit && (dest == IW'(gi))) ? sel_word : 8'b0;
        end
    endgenerate

endmodule

// File: rtl/state_mem_sequencer.sv
// Command sequencer around the FPU and the state memory. Optional perf counters
// (perf_ops, perf_errs) are built when SEQ_PERF_CNT_EN is defined.
module state_mem_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int NREG    = 16,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_dest,
    input  logic [$clog2(NREG)-1:0] cmd_src1,
    input  logic [$clog2(NREG)-1:0] cmd_src2,
    output logic [$clog2(NREG)-1:0] src1_sel,
    output logic [$clog2(NREG)-1:0] src2_sel,
    output logic                    fpu_start,
    input  logic                    fpu_done,
    output logic [8*NREG-1:0]       en_word,
    output logic                    busy,
    output logic                    op_done,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]             perf_ops,
    output logic [7:0]              perf_errs,
`endif
    output logic                    op_err
);

    localparam int IW = $clog2(NREG);

    state_t         state_reg, state_next;
    op_t            op_reg;
    logic [IW-1:0]  dest_reg;
    logic [IW-1:0]  src1_reg, src2_reg;
    logic [TW-1:0]  cnt_reg, cnt_next;
    logic           err_reg, err_next;
    logic           accept;

    assign accept = cmd_valid && (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            op_reg    <= OP_ADD;
            dest_reg  <= '0;
            src1_reg  <= '0;
            src2_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            // Operand selects stay put until the next accepted command.
            if (accept) begin
                op_reg   <= op_t'(cmd_op);
                dest_reg <= cmd_dest;
                src1_reg <= cmd_src1;
                src2_reg <= cmd_src2;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_fpu_op(op_t'(cmd_op)) ? ST_ISSUE : ST_COMMIT;
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + TW'(1);
                // A result arriving on the last allowed cycle still commits.
                if (fpu_done) begin
                    state_next = ST_COMMIT;
                end else if (cnt_reg == TW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign fpu_start = (state_reg == ST_ISSUE);
    assign op_done   = (state_reg == ST_COMMIT);
    assign op_err    = err_reg;
    assign src1_sel  = src1_reg;
    assign src2_sel  = src2_reg;

    wb_word_decoder #(
        .NREG (NREG)
    ) u_decoder (
        .dest    (dest_reg),
        .op      (op_reg),
        .commit  (op_done),
        .en_word (en_word)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_ops_reg;
    logic [7:0]  perf_errs_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perf_ops_reg  <= '0;
            perf_errs_reg <= '0;
        end else begin
            if (op_done && (perf_ops_reg != 16'hFFFF)) begin
                perf_ops_reg <= perf_ops_reg + 16'd1;
            end
            if (op_err && (perf_errs_reg != 8'hFF)) begin
                perf_errs_reg <= perf_errs_reg + 8'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_reg;
    assign perf_errs = perf_errs_reg;
`endif

endmodule

// File: tb/tb_state_mem_sequencer.sv
// Directed bench for state_mem_sequencer: a table of single commands with a
// bench-driven FPU latency, plus sequences for back-to-back, timeout and reset.
module tb_state_mem_sequencer;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [3:0]   cmd_dest, cmd_src1, cmd_src2;
    logic [3:0]   src1_sel, src2_sel;
    logic         fpu_start;
    logic         fpu_done;
    logic [127:0] en_word;
    logic         busy, op_done, op_err;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]  perf_ops;
    logic [7:0]   perf_errs;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    state_mem_sequencer #(.NREG(16), .TIMEOUT(64), .TW(7)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dest  (cmd_dest),
        .cmd_src1  (cmd_src1),
        .cmd_src2  (cmd_src2),
        .src1_sel  (src1_sel),
        .src2_sel  (src2_sel),
        .fpu_start (fpu_start),
        .fpu_done  (fpu_done),
        .en_word   (en_word),
        .busy      (busy),
        .op_done   (op_done),
`ifdef SEQ_PERF_CNT_EN
        .perf_ops  (perf_ops),
        .perf_errs (perf_errs),
`endif
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] dest;
        logic [3:0] src1;
        logic [3:0] src2;
        int         lat;      // FPU latency driven by the bench (0 = no FPU)
        int         bitidx;   // expected absolute en_word bit
        int         exp_lat;  // expected accept-to-op_done cycles
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dest  = d;
        cmd_src1  = s1;
        cmd_src2  = s2;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n, done_n, start_n, starts, stray, err_n, late;
        logic [127:0] exp;

        vecs[0] = '{3'd3, 4'd5,  4'd2, 4'd0, 0, 43,  1};
        vecs[1] = '{3'd0, 4'd15, 4'd1, 4'd2, 4, 120, 6};
        vecs[2] = '{3'd7, 4'd0,  4'd3, 4'd4, 0, 6,   1};
        vecs[3] = '{3'd6, 4'd1,  4'd5, 4'd6, 0, 15,  1};
        vecs[4] = '{3'd1, 4'd3,  4'd7, 4'd8, 1, 25,  3};
        vecs[5] = '{3'd2, 4'd7,  4'd9, 4'd10, 7, 58, 9};
        vecs[6] = '{3'd4, 4'd10, 4'd11, 4'd0, 0, 84, 1};
        vecs[7] = '{3'd5, 4'd12, 4'd13, 4'd0, 0, 101, 1};
        vecs[8] = '{3'd0, 4'd2,  4'd2, 4'd2, 2, 16,  4};

        n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dest = '0;
        cmd_src1 = '0; cmd_src2 = '0; fpu_done = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_en_word", en_word, 0);
        check("rst_fpu_start", fpu_start, 0);
        check("rst_op_done", op_done, 0);
        check("rst_op_err", op_err, 0);
        check("rst_src1_sel", src1_sel, 0);
        n_rst = 1'b1;
        tick();

        // Timeout: MUL with fpu_done held low
        send(3'd2, 4'd6, 4'd1, 4'd3);
        n = 1; start_n = 0; err_n = 0; stray = 0;
        while (err_n == 0 && n < 200) begin
            if (fpu_start) start_n = n;
            if (op_err) err_n = n;
            if (en_word != 0 || op_done) stray++;
            if (err_n == 0) begin tick(); n++; end
        end
        $display("timeout: fpu_start at %0d, op_err at %0d", start_n, err_n);
        check("timeout_delay", err_n - start_n, 65);
        check("timeout_no_write", stray, 0);
        check("timeout_idle", cmd_ready, 1);
        check("timeout_busy", busy, 0);
        tick();
        check("timeout_err_pulse", op_err, 0);
`ifdef SEQ_PERF_CNT_EN
        check("perf_errs", perf_errs, 1);
        check("perf_ops", perf_ops, 0);
`endif

        // Table of single commands
        for (int i = 0; i < 9; i++) begin
            exp = 128'd1 << vecs[i].bitidx;
            send(vecs[i].op, vecs[i].dest, vecs[i].src1, vecs[i].src2);
            n = 1; done_n = 0; start_n = 0; starts = 0; stray = 0;
            while (done_n == 0 && n < 100) begin
                if (fpu_start) begin starts++; start_n = n; end
                fpu_done = (vecs[i].lat > 0) && (starts > 0) && (n == start_n + vecs[i].lat);
                if (op_done) begin
                    done_n = n;
                    check($sformatf("v%0d_en_word", i), en_word, exp);
                end else if (en_word != 0) begin
                    stray++;
                end
                if (done_n == 0) begin tick(); n++; end
            end
            fpu_done = 1'b0;
            $display("vec %0d: op %0d dest %0d op_done after %0d cycles", i, vecs[i].op, vecs[i].dest, done_n);
            check($sformatf("v%0d_latency", i), done_n, vecs[i].exp_lat);
            check($sformatf("v%0d_starts", i), starts, (vecs[i].lat > 0) ? 1 : 0);
            check($sformatf("v%0d_stray", i), stray, 0);
            check($sformatf("v%0d_src1_sel", i), src1_sel, vecs[i].src1);
            check($sformatf("v%0d_src2_sel", i), src2_sel, vecs[i].src2);
            tick();
            check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
            check($sformatf("v%0d_en_clear", i), en_word, 0);
            check($sformatf("v%0d_sel_hold", i), src1_sel, vecs[i].src1);
        end

        // Back-to-back with cmd_valid held: second command ignored during COMMIT
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dest = 4'd4; cmd_src1 = 4'd1; cmd_src2 = 4'd0;
        tick();
        check("b2b_first_commit", en_word, 128'd1 << 35);
        cmd_op = 3'd6; cmd_dest = 4'd9; cmd_src1 = 4'd6;
        tick();
        check("b2b_ready_rise", cmd_ready, 1);
        check("b2b_idle_no_write", en_word, 0);
        tick();
        cmd_valid = 1'b0;
        check("b2b_second_commit", en_word, 128'd1 << 79);
        check("b2b_second_done", op_done, 1);
        check("b2b_second_sel", src1_sel, 6);
        $display("b2b: MOV r4 then IMM r9 at 2-cycle interval");
        tick();

        // Reset asserted two cycles after fpu_start, then a late fpu_done
        send(3'd0, 4'd8, 4'd3, 4'd4);
        check("midrst_start", fpu_start, 1);
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("midrst_en_word", en_word, 0);
        check("midrst_idle", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_fpu_start", fpu_start, 0);
        tick();
        n_rst = 1'b1;
        fpu_done = 1'b1;
        late = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (op_done || en_word != 0 || busy) late++;
        end
        fpu_done = 1'b0;
        $display("midrst: reset during WAIT, late fpu_done for 4 cycles");
        check("midrst_no_commit", late, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
